// File: rtl/apb_slave_pkg.sv
// Shared types and helpers for the APB register-file slave.
// Holds the transfer FSM encoding, the wait-counter width and the address-decode helpers.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Byte-offset bits below the word index.
    function automatic int lsb_of(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Transfer sequencing for the APB slave: IDLE -> (WAIT) -> READY, with a programmable
// number of PREADY-low access cycles and strobes marking the edges into and out of READY.
module apb_wait_ctrl
    import apb_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic enter_ready,
    output logic leave_ready
);

    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pready  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pready  <= (state_d == ST_READY);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel && !penable) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                // A master dropping PSEL mid-transfer abandons it outright.
                if (!psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_READY: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        enter_ready = (state_q != ST_READY) && (state_d == ST_READY);
        leave_ready = (state_q == ST_READY);
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave backed by a DEPTH x DATA_W register file with byte strobes, optional
// wait states and an error response for misaligned or out-of-range addresses.
module apb_regfile_slave
    import apb_slave_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int LSB   = lsb_of(DATA_W);
    localparam int IDX_W = idx_w_of(DEPTH);
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              enter_ready, leave_ready;
    logic              legal, do_write;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;

    apb_wait_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_ctrl (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .psel       (PSEL),
        .penable    (PENABLE),
        .pready     (PREADY),
        .enter_ready(enter_ready),
        .leave_ready(leave_ready)
    );

    always_comb begin
        idx     = PADDR[LSB +: IDX_W];
        legal   = (PADDR[LSB-1:0] == '0) && ((PADDR >> LSB) < ADDR_W'(DEPTH));
        rd_word = legal ? mem[idx] : '0;
    end

    // Writes commit as READY is left, so a following read always sees them.
    assign do_write = leave_ready && PSEL && PENABLE && PWRITE && legal;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < NB; b++)
                if (PSTRB[b]) mem[idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else begin
            if (enter_ready && !PWRITE) PRDATA <= rd_word;
            if (enter_ready)            PSLVERR <= !legal;
            else if (leave_ready)       PSLVERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboarded bench for apb_regfile_slave: three instances (0, 2 and 3 wait cycles)
// driven one at a time, checked against a byte-addressed reference memory.
module tb_apb_regfile_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [2:0]  psel_v = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    always #5 PCLK = ~PCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        apb_regfile_slave #(
            .DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(WC)
        ) u_dut (
            .PCLK   (PCLK),
            .PRESETn(PRESETn),
            .PSEL   (psel_v[g]),
            .PENABLE(penable),
            .PWRITE (pwrite),
            .PADDR  (paddr),
            .PWDATA (pwdata),
            .PSTRB  (pstrb),
            .PRDATA (prdata_v[g]),
            .PREADY (pready_v[g]),
            .PSLVERR(pslverr_v[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mbytes [3][64];
    logic [31:0] last_rd [3];
    int          cyc = 0;
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            last_rd[d] = '0;
            for (int a = 0; a < 64; a++) mbytes[d][a] = 8'h00;
        end
    endtask

    // Issue one full transfer on instance d; the expected completion is queued at setup.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        bit   ok, done;
        int   a;
        ok = (addr[1:0] == 2'b00) && (addr < 32'd64);
        a  = int'(addr[5:0]);
        if (!wr) last_rd[d] = ok ? {mbytes[d][a+3], mbytes[d][a+2], mbytes[d][a+1], mbytes[d][a]} : '0;
        e.d = d; e.rdata = last_rd[d]; e.err = !ok; e.exp_cyc = cyc + wc(d) + 1;
        sb.push_back(e);
        if (wr && ok)
            for (int b = 0; b < 4; b++) if (strb[b]) mbytes[d][a+b] = data[8*b +: 8];
        psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(posedge PCLK); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge PCLK);
            if (pready_v[d]) done = 1'b1;
        end
        check("xfer_completes", done, 1);
        @(posedge PCLK); #1;
        psel_v[d] = 1'b0; penable = 1'b0;
    endtask

    always @(negedge PCLK) begin
        for (int d = 0; d < 3; d++) begin
            if (pready_v[d]) begin
                bit expected;
                exp_t e;
                expected = (sb.size() > 0) && (sb[0].d == d);
                check("pready_expected", expected, 1);
                if (expected) begin
                    e = sb.pop_front();
                    check("latency", cyc, e.exp_cyc);
                    check("prdata", prdata_v[d], e.rdata);
                    check("pslverr", pslverr_v[d], e.err);
                end
            end else begin
                check("pslverr_without_pready", pslverr_v[d], 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #3;
        for (int d = 0; d < 3; d++) begin
            check("reset_prdata", prdata_v[d], 0);
            check("reset_pready", pready_v[d], 0);
            check("reset_pslverr", pslverr_v[d], 0);
        end
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;

        // Zero-wait instance: full word, partial strobe merge, illegal accesses.
        xfer(0, 1, 32'h08, 32'hDEADBEEF, 4'hF);
        xfer(0, 0, 32'h08, 32'h0, 4'h0);
        xfer(0, 1, 32'h0C, 32'hFFFFFFFF, 4'hF);
        xfer(0, 1, 32'h0C, 32'h12345678, 4'h5);
        xfer(0, 0, 32'h0C, 32'h0, 4'h0);
        xfer(0, 1, 32'h00, 32'h0BADF00D, 4'hF);
        xfer(0, 1, 32'h40, 32'h55555555, 4'hF);
        xfer(0, 0, 32'h02, 32'h0, 4'h0);
        xfer(0, 0, 32'h00, 32'h0, 4'h0);
        xfer(0, 1, 32'h04, 32'hA5A5A5A5, 4'h0);
        xfer(0, 0, 32'h04, 32'h0, 4'h0);

        // Three-wait instance: latency, then an aborted write.
        xfer(2, 0, 32'h04, 32'h0, 4'h0);
        xfer(2, 1, 32'h10, 32'h11223344, 4'hF);
        psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h99887766; pstrb = 4'hF;
        @(posedge PCLK); #1 penable = 1'b1;
        @(posedge PCLK); #1 psel_v[2] = 1'b0; penable = 1'b0;
        repeat (6) @(posedge PCLK);
        #1;
        xfer(2, 0, 32'h10, 32'h0, 4'h0);

        // Randomized traffic on every instance, mixing back-to-back and gapped transfers.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 50; n++) begin
                int          r;
                logic [31:0] addr;
                r = int'($urandom_range(0, 9));
                if (r < 8)       addr = 32'($urandom_range(0, 15) * 4);
                else if (r == 8) addr = 32'(64 + $urandom_range(0, 15) * 4);
                else             addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                xfer(d, bit'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge PCLK); #1;
                end
            end
        end

        // Reset asserted while a write sits in WAIT on the two-wait instance.
        xfer(1, 1, 32'h00, 32'hA5A51234, 4'hF);
        xfer(1, 0, 32'h00, 32'h0, 4'h0);
        psel_v[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h00; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge PCLK); #1 penable = 1'b1;
        #2 PRESETn = 1'b0;
        #1;
        check("async_reset_prdata", prdata_v[1], 0);
        check("async_reset_pready", pready_v[1], 0);
        check("async_reset_pslverr", pslverr_v[1], 0);
        model_reset();
        psel_v[1] = 1'b0; penable = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        xfer(1, 0, 32'h00, 32'h0, 4'h0);
        xfer(0, 0, 32'h08, 32'h0, 4'h0);
        xfer(1, 1, 32'h3C, 32'h600DCAFE, 4'hF);
        xfer(1, 0, 32'h3C, 32'h0, 4'h0);

        repeat (5) @(posedge PCLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, APB data width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, APB address width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_W words of storage (1..256).
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, number of PREADY-low access cycles per transfer (0..15).
REQ-005 SHALL have port PCLK, input, 1, clock; all state changes on the rising edge.
REQ-006 SHALL have port PRESETn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port PSEL, input, 1, slave select.
REQ-008 SHALL have port PENABLE, input, 1, access-phase indicator.
REQ-009 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W, byte address.
REQ-011 SHALL have port PWDATA, input, DATA_W, write data.
REQ-012 SHALL have port PSTRB, input, DATA_W/8, write byte-lane enables.
REQ-013 SHALL have port PRDATA, output, DATA_W, registered read data.
REQ-014 SHALL have port PREADY, output, 1, registered transfer-complete.
REQ-015 SHALL have port PSLVERR, output, 1, registered error response, valid only while PREADY = 1.

Function
REQ-016 SHALL use LSB = log2(DATA_W/8) and word index = PADDR[LSB +: log2(DEPTH)]; an address is legal iff PADDR[LSB-1:0] = 0 and PADDR >> LSB < DEPTH.
REQ-017 SHALL implement FSM states IDLE, WAIT and READY, with PREADY = 1 only in READY.
REQ-018 In IDLE with PSEL = 1 and PENABLE = 0 (setup): next state READY if WAIT_CYCLES = 0, else WAIT with counter = WAIT_CYCLES-1.
REQ-019 In WAIT with PSEL = 1: decrement the counter; when the counter = 0, next state is READY. Transfer latency from setup to PREADY = 1 is exactly WAIT_CYCLES+1 cycles.
REQ-020 READY SHALL always go to IDLE on the next edge; back-to-back transfers use the following cycle as setup.
REQ-021 On the edge entering READY for a read: PRDATA = mem[index] if legal, else 0; PRDATA SHALL hold its value at all other times.
REQ-022 On the edge leaving READY with PSEL & PENABLE & PWRITE & legal: write byte lane i of mem[index] only where PSTRB[i] = 1; with PSTRB = 0, no change.
REQ-023 PSLVERR SHALL be loaded with !legal on the edge entering READY and cleared on leaving READY; illegal writes SHALL NOT modify storage.
REQ-024 If PSEL drops in WAIT or READY (protocol abort), the FSM SHALL go to IDLE, perform no write, and clear PREADY and PSLVERR.
REQ-025 PADDR, PWRITE, PWDATA and PSTRB SHALL be sampled during the READY cycle; the master holds them stable per APB.
REQ-026 A read of a location in the same transfer pair as a preceding write SHALL return the written data (a write commits before the next setup).

Reset
REQ-027 Asserting PRESETn low SHALL immediately force IDLE, counter = 0, PREADY = 0, PSLVERR = 0, PRDATA = 0 and all mem words = 0, including mid-transfer; an in-flight write SHALL be discarded.
REQ-028 Deassertion SHALL be synchronised by the integrator; the first setup is accepted on the first edge after release.

Structure
REQ-029 Package apb_slave_pkg SHALL hold the FSM state enum, the WAIT counter width constant (4) and the LSB/index-width helper functions.
REQ-030 Sub-module apb_wait_ctrl SHALL contain the FSM and wait counter and output PREADY plus the enter_ready/leave_ready strobes; storage, decode and PSLVERR stay in the top level.

Verification
REQ-031 WAIT_CYCLES = 0: write 0xDEADBEEF to 0x08 with PSTRB = 0xF, then read 0x08 -> PREADY in the cycle after setup, PRDATA = 0xDEADBEEF, PSLVERR = 0.
REQ-032 WAIT_CYCLES = 3: read 0x04 -> exactly 3 PREADY-low access cycles, then PREADY = 1 for one cycle.
REQ-033 Write 0xFFFFFFFF, then write 0x12345678 with PSTRB = 0x5 to 0x0C, then read -> 0xFF34FF78.
REQ-034 DEPTH = 16: write to 0x40 and read 0x02 -> PSLVERR = 1 with PREADY, PRDATA = 0, storage unchanged.
REQ-035 WAIT_CYCLES = 2: assert PRESETn low during WAIT of a write to 0x00 -> outputs zero asynchronously, a later read of 0x00 returns 0.
REQ-036 Drop PSEL in WAIT -> FSM returns to IDLE, no write, and the next transfer completes normally.
